gfx256_rd_arbiter: RTL
======================

# gfx256_rd_arbiter

Read-port arbiter for the gfx256 pipeline. It shares the single 256-bit wishbone reader among NREQ requesters: clip z-buffer reads, texture fetch and destination reads for blending. Arbitration is round-robin and fair. The block owns the reader's request/address/select lines and returns the 256-bit line plus a one-cycle ack to the granted requester only.

## Interface
- NREQ, 3: number of requesters; index 0 = z-buffer, 1 = texture, 2 = blend destination.
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req_i  in  NREQ  per-requester read request; held high until that requester's ack.
- addr_i  in  32*NREQ  request address; slice r = bits [32r+31:32r]; stable while req high.
- sel_i  in  32*NREQ  byte selects, same slicing; stable while req high.
- ack_o  out  NREQ  one-cycle pulse to the granted requester; data_o is valid in the same cycle.
- data_o  out  256  registered read line.
- inval_i  in  1  invalidates the line cache; asserted by the writer on any memory write.
- m_request_o  out  1  request to the wishbone reader.
- m_addr_o  out  32  address to the reader.
- m_sel_o  out  32  byte selects to the reader.
- m_busy_i  in  1  reader busy; no new request may start while high.
- m_ack_i  in  1  reader completed; m_data_i is valid.
- m_data_i  in  256  read data.

## Operation
- State machine states:
  - IDLE: if any req_i is high, pick the first requester after last_grant (wrapping around) that has req high. Register grant, m_addr_o and m_sel_o from that requester's slice. Go to ISSUE, or to HIT on a cache hit.
  - ISSUE: m_request_o <= 1 when m_busy_i = 0 and stay. Once m_request_o is high it stays high until m_ack_i.
  - On m_ack_i: m_request_o <= 0, data_o <= m_data_i, ack_o[grant] <= 1, go to DONE.
  - HIT: data_o <= cached line, ack_o[grant] <= 1, go to DONE.
  - DONE: ack_o <= 0, last_grant <= grant, go to IDLE. This state gives the requester one cycle to drop req.
- Round-robin: last_grant resets to NREQ-1, so requester 0 wins the first contention. A requester that is continuously asserting is served within NREQ transactions.
- m_ack_i outside ISSUE is ignored.
- req_i dropped by a requester while it holds the grant is a protocol violation; the transaction still completes and the ack is still pulsed.

## Timing
- Reset values: ack_o = 0, data_o = 0, m_request_o = 0, m_addr_o = 0, m_sel_o = 32'hFFFFFFFF, state = IDLE, cache valid = 0. Reset applies immediately and asynchronously, including mid-transaction; a late m_ack_i after reset is ignored.
- Latency on the miss path:
  - req sampled at edge E.
  - m_request_o high after edge E+1 if m_busy_i is low.
  - m_ack_i seen at edge A gives ack_o/data_o after edge A; ack_o drops after A+1.
  - Earliest next grant is at A+2.
- Busy stall: each cycle m_busy_i is high in ISSUE before the request starts delays m_request_o by one cycle.
- Hit path: ack_o is high after edge E+1; the transaction is 3 cycles from req to the next grant.
- Simultaneous requests: exactly one grant per transaction; the others wait with req held.

## Configuration
- GFX256_RD_LINE_CACHE_EN defined: one-entry line cache.
  - Tag = addr[31:5] plus a valid bit, filled on every m_ack_i.
  - IDLE checks for a hit only when the winning addr[31:5] matches the tag and valid = 1.
  - inval_i clears valid. If inval_i and m_ack_i coincide, inval wins: data is still returned, but valid ends at 0.
- Undefined: no tag storage and no HIT state. Every request goes to the bus; inval_i is ignored.

## Test plan
- Single requester: req_i = 3'b001, addr = 32'h0000_1000, m_ack_i two cycles after m_request_o with data 256'hA5… -> ack_o = 3'b001 for one cycle, data_o = 256'hA5…, m_addr_o = 32'h1000.
- All three requesting continuously -> grants in order 0, 1, 2, 0, 1, 2; no requester acked twice before the others are served.
- m_busy_i held high 5 cycles after grant -> m_request_o stays 0 for those 5 cycles, rises on the first cycle busy is low, and is held until m_ack_i.
- With GFX256_RD_LINE_CACHE_EN: two reads to 32'h2000 then 32'h201C -> one bus transaction, second ack 2 cycles after its req. Repeat with inval_i pulsed between the reads -> two bus transactions.
- Reset (rst_i = 0) asserted while in ISSUE with m_request_o high -> m_request_o = 0 immediately. After release, a stray m_ack_i produces no ack_o.

Source files
------------

// File: rtl/gfx256_rd_arbiter_if.sv
// gfx256_rd_arbiter_if
//   Bundles the requester side (req/addr/sel/ack/data/inval) and the
//   wishbone-reader side (m_*) of the gfx256 read-port arbiter.
//   Address and select buses are NREQ 32-bit slices, slice r = [32r+31:32r].
//   modport master : the arbiter (drives acks, returned line and reader request)
//   modport slave  : the environment (requesters plus the wishbone reader)
interface gfx256_rd_arbiter_if #(parameter int NREQ = 3);
    logic [NREQ-1:0]      req_i;
    logic [32*NREQ-1:0]   addr_i;
    logic [32*NREQ-1:0]   sel_i;
    logic [NREQ-1:0]      ack_o;
    logic [255:0]         data_o;
    logic                 inval_i;
    logic                 m_request_o;
    logic [31:0]          m_addr_o;
    logic [31:0]          m_sel_o;
    logic                 m_busy_i;
    logic                 m_ack_i;
    logic [255:0]         m_data_i;

    modport master (
        input  req_i, addr_i, sel_i, inval_i, m_busy_i, m_ack_i, m_data_i,
        output ack_o, data_o, m_request_o, m_addr_o, m_sel_o
    );

    modport slave (
        output req_i, addr_i, sel_i, inval_i, m_busy_i, m_ack_i, m_data_i,
        input  ack_o, data_o, m_request_o, m_addr_o, m_sel_o
    );
endinterface

// File: rtl/gfx256_rd_arbiter.sv
// gfx256_rd_arbiter
//   Round-robin arbiter sharing one 256-bit wishbone reader among NREQ
//   requesters (0 = z-buffer, 1 = texture, 2 = blend destination).
//   Ports:
//     clk_i  - clock, rising edge
//     rst_i  - asynchronous active-low reset
//     bus    - gfx256_rd_arbiter_if.master (requester and reader signals)
//   Optional feature: define GFX256_RD_LINE_CACHE_EN for a one-entry line
//   cache (tag = addr[31:5]); without it every request goes to the reader
//   and inval_i is ignored.
module gfx256_rd_arbiter #(
    parameter int NREQ = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    gfx256_rd_arbiter_if.master   bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef logic [GW-1:0] gidx_t;

`ifdef GFX256_RD_LINE_CACHE_EN
    typedef enum logic [1:0] {IDLE, ISSUE, HIT, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
`endif

    state_t           state_q, state_d;
    gidx_t            grant_q, grant_d;
    gidx_t            last_q,  last_d;
    logic             mreq_q,  mreq_d;
    logic [31:0]      maddr_q, maddr_d;
    logic [31:0]      msel_q,  msel_d;
    logic [NREQ-1:0]  ack_q,   ack_d;
    logic [255:0]     data_q,  data_d;

    logic             pick_vld;
    gidx_t            pick_idx;
    logic [31:0]      pick_addr;
    logic [31:0]      pick_sel;

`ifdef GFX256_RD_LINE_CACHE_EN
    logic [26:0]      tag_q, tag_d;
    logic             valid_q, valid_d;
    logic             hit;
`endif

    // Round-robin pick: walk from farthest to nearest after last_q so the
    // nearest asserted requester overwrites the others.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = NREQ; i >= 1; i--) begin
            if (bus.req_i[(int'(last_q) + i) % NREQ]) begin
                pick_vld = 1'b1;
                pick_idx = gidx_t'((int'(last_q) + i) % NREQ);
            end
        end
    end

    assign pick_addr = bus.addr_i[{pick_idx, 5'b0} +: 32];
    assign pick_sel  = bus.sel_i[{pick_idx, 5'b0} +: 32];

`ifdef GFX256_RD_LINE_CACHE_EN
    // A same-cycle invalidate must not let a stale line be returned.
    assign hit = valid_q && !bus.inval_i && (pick_addr[31:5] == tag_q);
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        mreq_d  = mreq_q;
        maddr_d = maddr_q;
        msel_d  = msel_q;
        ack_d   = '0;
        data_d  = data_q;
`ifdef GFX256_RD_LINE_CACHE_EN
        tag_d   = tag_q;
        valid_d = valid_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    maddr_d = pick_addr;
                    msel_d  = pick_sel;
`ifdef GFX256_RD_LINE_CACHE_EN
                    state_d = hit ? HIT : ISSUE;
`else
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: begin
                if (mreq_q && bus.m_ack_i) begin
                    mreq_d         = 1'b0;
                    data_d         = bus.m_data_i;
                    ack_d[grant_q] = 1'b1;
                    state_d        = DONE;
`ifdef GFX256_RD_LINE_CACHE_EN
                    tag_d   = maddr_q[31:5];
                    valid_d = 1'b1;
`endif
                end else if (!mreq_q && !bus.m_busy_i) begin
                    mreq_d = 1'b1;
                end
            end
`ifdef GFX256_RD_LINE_CACHE_EN
            // data_q always holds the most recent fill, which is exactly the
            // cached line, so a hit just re-presents it with a fresh ack.
            HIT: begin
                ack_d[grant_q] = 1'b1;
                state_d        = DONE;
            end
`endif
            DONE: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef GFX256_RD_LINE_CACHE_EN
        // Invalidate beats a coincident fill.
        if (bus.inval_i) valid_d = 1'b0;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= gidx_t'(NREQ - 1);
            mreq_q  <= 1'b0;
            maddr_q <= '0;
            msel_q  <= 32'hFFFF_FFFF;
            ack_q   <= '0;
            data_q  <= '0;
`ifdef GFX256_RD_LINE_CACHE_EN
            tag_q   <= '0;
            valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            mreq_q  <= mreq_d;
            maddr_q <= maddr_d;
            msel_q  <= msel_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
`ifdef GFX256_RD_LINE_CACHE_EN
            tag_q   <= tag_d;
            valid_q <= valid_d;
`endif
        end
    end

    assign bus.m_request_o = mreq_q;
    assign bus.m_addr_o    = maddr_q;
    assign bus.m_sel_o     = msel_q;
    assign bus.ack_o       = ack_q;
    assign bus.data_o      = data_q;
endmodule
